// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: per-stage stall/flush
// strobes for load-use, EX redirects, multi-cycle MDU occupancy and dmem waits.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_regread1,
    input  logic             ID_regread2,
    input  logic             EX_memread,
    input  logic             EX_regwrite,
    input  logic [4:0]       EX_wraddr,
    input  logic             EX_redirect,
    input  logic             EX_mdu_start,
    input  logic             MEM_memaccess,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {RUN, BUSY} state_t;

    localparam logic [7:0] BUSY_CNT = 8'(MDU_LAT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       memwait;
    logic       loaduse;
    logic       flush_acc;
    logic       mdu_go;

    assign memwait = MEM_memaccess & ~dmem_ready;
    assign loaduse = EX_memread & EX_regwrite & (EX_wraddr != 5'd0) &
                     ((ID_regread1 & (ID_rs == EX_wraddr)) |
                      (ID_regread2 & (ID_rt == EX_wraddr)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;
        flush_acc    = 1'b0;
        mdu_go       = 1'b0;
        if (!rst) begin
            mdu_busy = (state == BUSY);
            // A data-memory wait freezes everything up to MEM and defers every
            // other decision to the cycle the access completes.
            if (memwait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (state == RUN) begin
                if (EX_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_acc   = 1'b1;
                end else if (EX_mdu_start) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mdu_go       = 1'b1;
                end else if (loaduse) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end else if (cnt > 8'd1) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else begin
                // Final MDU cycle: the result leaves EX, so a load-use in ID
                // still needs its bubble here.
                mdu_done = 1'b1;
                if (loaduse) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= 8'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            case (state)
                RUN: if (mdu_go) begin
                    state <= BUSY;
                    cnt   <= BUSY_CNT;
                end
                BUSY: if (!memwait) begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= RUN;
                        cnt   <= 8'd0;
                    end
                end
                default: state <= RUN;
            endcase
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush_acc && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle RUN vectors plus
// hand-written MDU/memwait/reset/saturation sequences, scoreboard-compared.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rr1;
        logic       rr2;
        logic       mr;
        logic       rw;
        logic [4:0] wa;
        logic       redir;
        logic       mdu;
        logic       macc;
        logic       drdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
        string      name;
    } vec_t;

    // Bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    // ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_LU   = 10'b1100100000;
    localparam logic [9:0] O_RD   = 10'b0010100000;
    localparam logic [9:0] O_MW   = 10'b1101010100;
    localparam logic [9:0] O_MS   = 10'b1101001000;
    localparam logic [9:0] O_B    = 10'b0000000010;
    localparam logic [9:0] O_D    = 10'b0000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int nchk = 0;
    int nerr = 0;
    logic [9:0] q[$];
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(cur.rs), .ID_rt(cur.rt),
        .ID_regread1(cur.rr1), .ID_regread2(cur.rr2),
        .EX_memread(cur.mr), .EX_regwrite(cur.rw), .EX_wraddr(cur.wa),
        .EX_redirect(cur.redir), .EX_mdu_start(cur.mdu),
        .MEM_memaccess(cur.macc), .dmem_ready(cur.drdy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic rr1, logic rr2,
                               logic mr, logic rw, logic [4:0] wa, logic redir,
                               logic mdu, logic macc, logic drdy);
        in_t r;
        r = '{rs, rt, rr1, rr2, mr, rw, wa, redir, mdu, macc, drdy};
        return r;
    endfunction

    function automatic in_t idle();
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic in_t lu8();
        return mk(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic int sat(int v);
        return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
    endfunction

    // Drive one cycle, check strobes mid-cycle, then advance the counter model.
    task automatic step(input in_t i, input logic [9:0] e, input string nm);
        logic [9:0] got, want;
        cur = i;
        q.push_back(e);
        @(negedge clk);
        got = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done};
        nchk++;
        if (q.size() == 0) begin
            nerr++;
            $display("FAIL %s: scoreboard empty, got %b", nm, got);
        end else begin
            want = q.pop_front();
            if (got !== want) begin
                nerr++;
                $display("FAIL %s: strobes got %b required %b", nm, got, want);
            end
            if (rst) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                m_stall = sat(m_stall + int'(want[9]));
                m_flush = sat(m_flush + int'(want[7]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string nm);
        nchk++;
        if (stall_cycles !== CNT_W'(m_stall) || flush_events !== CNT_W'(m_flush)) begin
            nerr++;
            $display("FAIL %s: stall_cycles/flush_events got %0d/%0d required %0d/%0d",
                     nm, stall_cycles, flush_events, m_stall, m_flush);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        tbl[0]  = '{idle(), O_NONE, "idle"};
        tbl[1]  = '{lu8(), O_LU, "loaduse_rs"};
        tbl[2]  = '{mk(5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), O_NONE, "loaduse_r0"};
        tbl[3]  = '{mk(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1), O_LU, "loaduse_rt"};
        tbl[4]  = '{mk(5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1), O_NONE, "rt_noread"};
        tbl[5]  = '{mk(5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1), O_NONE, "not_load"};
        tbl[6]  = '{mk(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1), O_NONE, "no_regwrite"};
        tbl[7]  = '{mk(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1), O_RD, "redirect_over_lu"};
        tbl[8]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), O_MW, "memwait"};
        tbl[9]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), O_MW, "memwait_redirect"};
        tbl[10] = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), O_NONE, "mem_ready"};
        tbl[11] = '{mk(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0), O_MW, "memwait_over_lu"};

        cur = lu8();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(lu8(), O_NONE, "reset_gates_strobes");
        rst = 1'b0;
        chk_cnt("reset_counters");

        for (int k = 0; k < 12; k++) step(tbl[k].in, tbl[k].exp, tbl[k].name);
        chk_cnt("table_counters");

        // MDU sequence, redirect in BUSY ignored
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), O_MS, "mdu_t0");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), O_MS | O_B, "mdu_t1_redir_ign");
        step(idle(), O_MS | O_B, "mdu_t2");
        step(idle(), O_B | O_D, "mdu_t3_done");
        step(idle(), O_NONE, "mdu_t4_run");
        chk_cnt("mdu_counters");

        // MDU with memwait at T2
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), O_MS, "mw_t0");
        step(idle(), O_MS | O_B, "mw_t1");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), O_MW | O_B, "mw_t2_wait");
        step(idle(), O_MS | O_B, "mw_t3_held");
        step(idle(), O_B | O_D, "mw_t4_done");
        step(idle(), O_NONE, "mw_t5_run");
        chk_cnt("mw_counters");

        // Deferred redirect after memwait
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), O_MW, "defer_wait");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), O_RD, "defer_redirect");

        // Redirect wins over MDU start; no BUSY afterwards
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1), O_RD, "redir_over_mdu");
        step(idle(), O_NONE, "no_busy_after");
        chk_cnt("redir_counters");

        // Load-use during the final MDU cycle
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), O_MS, "lu_t0");
        step(idle(), O_MS | O_B, "lu_t1");
        step(idle(), O_MS | O_B, "lu_t2");
        step(lu8(), O_LU | O_B | O_D, "lu_t3_done");
        step(idle(), O_NONE, "lu_t4_run");

        // Reset mid-BUSY
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), O_MS, "rb_t0");
        step(idle(), O_MS | O_B, "rb_t1");
        rst = 1'b1;
        step(idle(), O_NONE, "rb_reset");
        rst = 1'b0;
        step(idle(), O_NONE, "rb_after");
        chk_cnt("rb_counters");

        // Saturation: stall_cycles and flush_events stick at all-ones
        for (int k = 0; k < 20; k++) step(lu8(), O_LU, "sat_lu");
        chk_cnt("sat_stall");
        for (int k = 0; k < 18; k++)
            step(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), O_RD, "sat_rd");
        chk_cnt("sat_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
